display_pane_2: RTL and testbench
=================================

# display_pane_2

Pixel source for the VGA path. It walks a 640x480 frame in raster order and fetches each pixel from an 80x60 image ROM, with 24-bit RGB and every texel replicated 8x8. It pushes one pixel per clock into the downstream display FIFO and stalls on the FIFO's full flag. It sits between the image ROM and the pixel FIFO that feeds the VGA timing generator.

## Interface
Parameters:
- H_PIXELS, 640, active pixels per line.
- V_PIXELS, 480, active lines per frame.
- SCALE_SHIFT, 3, log2 of the replication factor (8x8 screen pixels per texel).
- IMG_W, 80, ROM image width in texels (H_PIXELS >> SCALE_SHIFT).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- fifo_full  in  1  downstream FIFO full; no write may be issued while it is high.
- in_pixel  in  24  ROM read data {R[23:16],G[15:8],B[7:0]}. It is valid one clock after rom_addr is presented (synchronous ROM).
- fifo_wr  out  1  FIFO write strobe; out_pixel is written when it is high.
- rom_addr  out  13  ROM texel address.
- out_pixel  out  24  pixel data to the FIFO.

## Operation
- State:
  - x counter (10 bit, 0..H_PIXELS-1).
  - y counter (9 bit, 0..V_PIXELS-1).
  - primed flag (1 bit).
- Reset (rst high at a rising edge): x=0, y=0, primed=0.
- Outputs during reset and the following cycle: fifo_wr=0, out_pixel=0, rom_addr=0.
- primed is set to 1 at the first rising edge with rst low, and stays 1 until the next reset.
- fifo_wr = primed & ~fifo_full. This is combinational, with no extra register stage.
- out_pixel = primed ? in_pixel : 24'h0. This is combinational passthrough.
- Advance condition: advance = fifo_wr. On advance:
  - x increments.
  - If x==H_PIXELS-1: x→0 and y increments.
  - If additionally y==V_PIXELS-1: y→0. The frame wraps and streaming continues indefinitely; there is no end-of-frame stall.
- Address mapping is addr(x,y) = (y >> SCALE_SHIFT)*IMG_W + (x >> SCALE_SHIFT).
  - The range is 0..4799.
  - The computation is 13 bits wide and never overflows.
  - The multiply by 80 is implemented as (v<<6)+(v<<4).
- Lookahead addressing, so that in_pixel always matches the current (x,y):
  - rom_addr = addr(next_x,next_y) when advance is high.
  - Otherwise rom_addr = addr(x,y).
- Stall (fifo_full=1 while primed):
  - fifo_wr=0.
  - Counters hold.
  - rom_addr holds addr(x,y), so in_pixel keeps re-presenting the same pixel.
  - No pixel is lost or duplicated.
- Reset mid-frame: the frame is abandoned. The restart is identical to power-up, with the first write being pixel (0,0) two cycles later.
- fifo_full while not primed has no effect.

## Timing
- Cycle R: last edge with rst high.
- Cycle R+1: rst low; rom_addr=0; fifo_wr=0.
- Cycle R+2: in_pixel=ROM[0]; fifo_wr=~fifo_full; this is the first write, pixel (0,0).
- Throughput is one pixel per clock while fifo_full=0.
- Stall response is zero-latency: fifo_wr drops in the same cycle fifo_full rises.
- Resume: the first write occurs in the cycle fifo_full falls, carrying the held pixel.
- One frame is 307200 writes. The write after (639,479) is (0,0), with rom_addr=0.
- rom_addr changes only in cycles where fifo_wr=1, or in the first cycle after reset.

## Test plan
- Reset: hold rst for 5 clocks with fifo_full=0 → fifo_wr=0, out_pixel=0, rom_addr=0 throughout. First fifo_wr=1 occurs exactly 2 clocks after rst falls, with out_pixel=ROM[0].
- Streaming/replication: ROM model ROM[a]=a. Over the first 16 writes, out_pixel = 0 for writes 0..7 and 1 for writes 8..15. The write at line y=8, x=0 carries 80.
- Backpressure: assert fifo_full for 50 clocks mid-line (the bench pulses it after 10 µs at 50 MHz for 1 µs, twice) → fifo_wr=0 in each full cycle and rom_addr stable. After release, the write sequence is contiguous with no gap or repeat.
- Line and frame wrap:
  - The write after x=639 of line 7 has rom_addr=80.
  - The last write of the frame carries 4799.
  - The next write carries 0 and no stall cycle is inserted.
- Reset mid-frame: assert rst at line 100 for 1 clock → the next writes restart at 0,0,0,… with 2-cycle latency.
- Random fifo_full (50% duty over 2 frames) → the sequence of written pixels exactly equals the golden raster order, 614400 writes.

Source files
------------

// File: rtl/display_pane_2.sv
// Raster-order pixel source: walks the active frame, looks up each pixel in an
// up-scaled texel ROM one clock ahead, and streams it into the display FIFO.
module display_pane_2 #(
  parameter int H_PIXELS    = 640,
  parameter int V_PIXELS    = 480,
  parameter int SCALE_SHIFT = 3,
  parameter int IMG_W       = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_full,
  input  logic [23:0] in_pixel,
  output logic        fifo_wr,
  output logic [12:0] rom_addr,
  output logic [23:0] out_pixel
);

  logic [9:0] x, nx;
  logic [8:0] y, ny;
  logic       primed;
  logic       advance;

  // Texel address of a screen coordinate; the constant multiply reduces to shift-adds.
  function automatic logic [12:0] addr_of(input logic [9:0] xx, input logic [8:0] yy);
    logic [12:0] row;
    logic [12:0] col;
    row = 13'(yy >> SCALE_SHIFT);
    col = 13'(xx >> SCALE_SHIFT);
    return row * 13'(IMG_W) + col;
  endfunction

  // Outputs are forced quiet while rst is high so an abandoned frame emits nothing.
  assign fifo_wr   = primed & ~fifo_full & ~rst;
  assign advance   = fifo_wr;
  assign out_pixel = (primed & ~rst) ? in_pixel : 24'h0;

  always_comb begin
    nx = x + 10'd1;
    ny = y;
    if (x == 10'(H_PIXELS - 1)) begin
      nx = '0;
      ny = (y == 9'(V_PIXELS - 1)) ? 9'd0 : y + 9'd1;
    end
  end

  // Look one pixel ahead on a write so the synchronous ROM data lines up with (x,y).
  always_comb begin
    rom_addr = '0;
    if (!rst) rom_addr = advance ? addr_of(nx, ny) : addr_of(x, y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (advance) begin
        x <= nx;
        y <= ny;
      end
    end
  end

endmodule

// File: tb/tb_display_pane_2.sv
// Directed bench for display_pane_2 on a reduced 128x64 frame (16x8 texels).
module tb_display_pane_2;

  localparam int H = 128;
  localparam int V = 64;
  localparam int S = 3;
  localparam int W = H >> S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_full = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        fifo_wr;
  logic [12:0] rom_addr;
  logic [23:0] out_pixel;

  display_pane_2 #(.H_PIXELS(H), .V_PIXELS(V), .SCALE_SHIFT(S), .IMG_W(W)) dut (
    .clk(clk), .rst(rst), .fifo_full(fifo_full), .in_pixel(in_pixel),
    .fifo_wr(fifo_wr), .rom_addr(rom_addr), .out_pixel(out_pixel)
  );

  always #10 clk = ~clk;

  // Synchronous ROM with ROM[a] = a.
  always @(posedge clk) in_pixel <= {11'd0, rom_addr};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int golden(input int gx, input int gy);
    return (gy >> S) * W + (gx >> S);
  endfunction

  // Raster scoreboard
  int gx = 0, gy = 0, since_rst = 0, total_wr = 0;
  bit log_en = 1'b0;
  logic [23:0] wr_log[$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_wr", 32'(fifo_wr), 0);
      check("rst_pix", 32'(out_pixel), 0);
      check("rst_addr", 32'(rom_addr), 0);
      gx = 0; gy = 0; since_rst = 0;
    end else begin
      since_rst++;
      if (since_rst == 1) begin
        check("first_wr", 32'(fifo_wr), 0);
        check("first_addr", 32'(rom_addr), 0);
        check("first_pix", 32'(out_pixel), 0);
      end else begin
        check("wr_strobe", 32'(fifo_wr), 32'(!fifo_full));
        if (fifo_wr) begin
          check("pixel", 32'(out_pixel), 32'(golden(gx, gy)));
          if (log_en) wr_log.push_back(out_pixel);
          total_wr++;
          gx++;
          if (gx == H) begin
            gx = 0; gy++;
            if (gy == V) gy = 0;
          end
          check("addr_next", 32'(rom_addr), 32'(golden(gx, gy)));
        end else begin
          check("addr_hold", 32'(rom_addr), 32'(golden(gx, gy)));
        end
      end
    end
  end

  typedef struct {
    int idx;
    int exp;
  } vec_t;

  vec_t vecs[13];
  logic [12:0] held;
  int start_wr;
  bit done;

  initial begin
    vecs = '{
      '{0, 0}, '{7, 0}, '{8, 1}, '{15, 1}, '{16, 2}, '{127, 15},
      '{128, 0}, '{1023, 15}, '{1024, 16}, '{1032, 17},
      '{8191, 127}, '{8192, 0}, '{8200, 1}
    };

    // Reset held five clocks, then free-running stream.
    log_en = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 9000 && !done; c++) begin
      @(posedge clk);
      if (wr_log.size() >= 8201) done = 1'b1;
    end
    log_en = 1'b0;
    check("stream_timeout", 32'(done), 1);
    for (int i = 0; i < 13; i++)
      if (vecs[i].idx < wr_log.size())
        check($sformatf("vec_w%0d", vecs[i].idx), 32'(wr_log[vecs[i].idx]), 32'(vecs[i].exp));
      else
        check($sformatf("vec_w%0d_missing", vecs[i].idx), 0, 1);

    // Two 50-cycle backpressure pulses mid-stream.
    for (int p = 0; p < 2; p++) begin
      repeat (500) @(posedge clk);
      #2 fifo_full = 1'b1;
      @(negedge clk);
      held = rom_addr;
      for (int i = 0; i < 50; i++) begin
        if (i > 0) @(negedge clk);
        check("stall_wr", 32'(fifo_wr), 0);
        check("stall_addr", 32'(rom_addr), 32'(held));
      end
      @(posedge clk);
      #2 fifo_full = 1'b0;
      @(negedge clk);
      check("resume_wr", 32'(fifo_wr), 1);
      check("resume_pix", 32'(out_pixel), 32'(held));
    end

    // Reset in the middle of line 40.
    done = 1'b0;
    for (int c = 0; c < 12000 && !done; c++) begin
      @(posedge clk);
      if (gy == 40 && gx > 10) done = 1'b1;
    end
    check("line40_timeout", 32'(done), 1);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wr1", 32'(fifo_wr), 0);
    check("mid_rst_addr1", 32'(rom_addr), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_wr", 32'(fifo_wr), 1);
      check("mid_rst_pix", 32'(out_pixel), 0);
    end

    // Random backpressure across two complete frames from a fresh reset.
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    start_wr = total_wr;
    done = 1'b0;
    for (int c = 0; c < 40000 && !done; c++) begin
      @(posedge clk);
      #2 fifo_full = 1'($urandom_range(0, 1));
      if (total_wr - start_wr >= 2 * H * V) done = 1'b1;
    end
    fifo_full = 1'b0;
    check("random_timeout", 32'(done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
